// File: rtl/music_sequencer_if.sv
// -----------------------------------------------------------------------------
// music_sequencer_if
//
// Purpose: note-command handshake between a note source (ROM/FSM) and the
// square-wave note player. The source presents a command and waits for busy
// to fall before presenting the next one.
//
// Signals:
//   command [11:0] : [11:8] duration in units (0 = no command),
//                    [7:0]  half-period in pitch units (0 = rest)
//   busy           : high while a note is playing
//   q              : square-wave audio output (speaker/buzzer pin)
//
// Modports:
//   master : note source   (drives command, observes busy and q)
//   slave  : note player   (consumes command, drives busy and q)
// -----------------------------------------------------------------------------
interface music_sequencer_if;

   logic [11:0] command;
   logic        busy;
   logic        q;

   modport master (
      output command,
      input  busy,
      input  q
   );

   modport slave (
      input  command,
      output busy,
      output q
   );

endinterface

// File: rtl/music_sequencer.sv
// -----------------------------------------------------------------------------
// music_sequencer
//
// Purpose: single-voice square-wave note player. A nonzero duration field on
// the command starts a note while idle; the note then plays for exactly
// D*TICK_DIV clock cycles with q toggling every P*NOTE_DIV cycles. A pitch of
// zero is a rest: busy behaves normally but q stays low.
//
// Parameters:
//   NOTE_DIV : clk cycles per pitch unit (tone prescale)
//   TICK_DIV : clk cycles per duration unit
//
// Ports:
//   clk   : system clock, all logic on the rising edge
//   reset : synchronous, active-high reset (has priority over a new command)
//   bus   : slave side of music_sequencer_if (command in, busy/q out)
//
// All registers also carry their reset value as a power-up value, so the
// block behaves correctly with reset tied low.
// -----------------------------------------------------------------------------
module music_sequencer #(
   parameter int NOTE_DIV = 1,
   parameter int TICK_DIV = 512
) (
   input  logic               clk,
   input  logic               reset,
   music_sequencer_if.slave   bus
);

   // Counter widths: the duration counter must reach 15*TICK_DIV-1 and the
   // pitch counter must hold a half-period of up to 255*NOTE_DIV cycles.
   localparam int DUR_W   = $clog2(15 * TICK_DIV + 1);
   localparam int PITCH_W = $clog2(255 * NOTE_DIV + 1);

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   state_t               state_q      = IDLE;
   state_t               state_d;
   logic                 busy_q       = 1'b0;
   logic                 busy_d;
   logic                 tone_q       = 1'b0;
   logic                 tone_d;
   logic [DUR_W-1:0]     dur_cnt_q    = '0;
   logic [DUR_W-1:0]     dur_cnt_d;
   logic [DUR_W-1:0]     dur_last_q   = '0;
   logic [DUR_W-1:0]     dur_last_d;
   logic [PITCH_W-1:0]   pitch_cnt_q  = '0;
   logic [PITCH_W-1:0]   pitch_cnt_d;
   logic [PITCH_W-1:0]   half_q       = '0;
   logic [PITCH_W-1:0]   half_d;

   logic                 cmd_valid;
   logic [DUR_W-1:0]     cmd_units;
   logic [PITCH_W-1:0]   cmd_pitch;
   logic                 note_done;
   logic                 half_done;

   assign cmd_valid = (bus.command[11:8] != 4'd0);
   assign cmd_units = DUR_W'(bus.command[11:8]);
   assign cmd_pitch = PITCH_W'(bus.command[7:0]);

   // The latched command is kept in pre-scaled form: the index of the last
   // cycle of the note and the half-period in clk cycles. This keeps the
   // multipliers on the command input only, off the per-cycle compare path.
   assign note_done = (dur_cnt_q == dur_last_q);
   assign half_done = (pitch_cnt_q == (half_q - PITCH_W'(1)));

   // Next-state logic for the IDLE/PLAY machine and both counters.
   // The end-of-note branch wins over tone toggling so that q is forced low
   // on the very edge busy falls.
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      tone_d      = tone_q;
      dur_cnt_d   = dur_cnt_q;
      dur_last_d  = dur_last_q;
      pitch_cnt_d = pitch_cnt_q;
      half_d      = half_q;

      case (state_q)
         IDLE: begin
            busy_d      = 1'b0;
            tone_d      = 1'b0;
            dur_cnt_d   = '0;
            pitch_cnt_d = '0;
            if (cmd_valid) begin
               state_d    = PLAY;
               busy_d     = 1'b1;
               dur_last_d = (cmd_units * DUR_W'(TICK_DIV)) - DUR_W'(1);
               half_d     = cmd_pitch * PITCH_W'(NOTE_DIV);
            end
         end

         PLAY: begin
            if (note_done) begin
               state_d     = IDLE;
               busy_d      = 1'b0;
               tone_d      = 1'b0;
               dur_cnt_d   = '0;
               pitch_cnt_d = '0;
            end else begin
               dur_cnt_d = dur_cnt_q + DUR_W'(1);
               // A zero half-period is a rest: the tone stays low and the
               // pitch counter is left parked at zero.
               if (half_q != '0) begin
                  if (half_done) begin
                     tone_d      = ~tone_q;
                     pitch_cnt_d = '0;
                  end else begin
                     pitch_cnt_d = pitch_cnt_q + PITCH_W'(1);
                  end
               end
            end
         end

         default: begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            tone_d      = 1'b0;
            dur_cnt_d   = '0;
            pitch_cnt_d = '0;
         end
      endcase
   end

   // State register. Reset is synchronous and clears everything, including
   // the latched note, so a command present during reset is never started.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         tone_q      <= 1'b0;
         dur_cnt_q   <= '0;
         dur_last_q  <= '0;
         pitch_cnt_q <= '0;
         half_q      <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         tone_q      <= tone_d;
         dur_cnt_q   <= dur_cnt_d;
         dur_last_q  <= dur_last_d;
         pitch_cnt_q <= pitch_cnt_d;
         half_q      <= half_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.q    = tone_q;

endmodule

// File: tb/tb_music_sequencer.sv
// -----------------------------------------------------------------------------
// tb_music_sequencer
//
// Directed bench for music_sequencer with default parameters
// (NOTE_DIV = 1, TICK_DIV = 512). Each scenario task drives the interface
// and compares busy length, the q waveform, rising-edge counts and idle
// behaviour against hand-computed values.
// -----------------------------------------------------------------------------
module tb_music_sequencer;

   localparam int TICK = 512;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int   tests_run = 0;
   int   tests_failed = 0;

   music_sequencer_if bus ();

   music_sequencer #(
      .NOTE_DIV (1),
      .TICK_DIV (TICK)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Global watchdog so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one rising edge and move to a sampling point away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Follow a note from just after its start edge until busy falls.
   // Expected q at cycle k is derived from the half-period h alone:
   // q = (k / h) % 2 while the note is playing (0 for a rest).
   task automatic measure_note(input int h, output int busy_len, output int q_err,
                               output int rises, output int first_rise,
                               output logic q_end);
      logic prev;
      logic exp_q;
      prev       = bus.q;
      busy_len   = -1;
      q_err      = 0;
      rises      = 0;
      first_rise = -1;
      q_end      = 1'bx;
      for (int k = 1; k <= 20000; k++) begin
         tick();
         if (bus.busy !== 1'b1) begin
            busy_len = k;
            q_end    = bus.q;
            break;
         end
         exp_q = (h == 0) ? 1'b0 : 1'(((k / h) % 2));
         if (bus.q !== exp_q) q_err++;
         if (bus.q === 1'b1 && prev === 1'b0) begin
            rises++;
            if (first_rise < 0) first_rise = k;
         end
         prev = bus.q;
      end
   endtask

   // Power-up with reset tied low and 0x43F already presented; the command
   // is changed to 0x840 mid-note and must not disturb the running note.
   task automatic test_power_up();
      int len, qerr, rises, first;
      logic qend;
      #1;
      tests_run++;
      if (bus.busy !== 1'b0 || bus.q !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL powerup_state: busy=%b q=%b, expected busy=0 q=0", bus.busy, bus.q);
      end
      tick();
      tests_run++;
      if (bus.busy !== 1'b1 || bus.q !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL powerup_start: busy=%b q=%b, expected busy=1 q=0", bus.busy, bus.q);
      end
      bus.command = 12'h840;
      measure_note(63, len, qerr, rises, first, qend);
      tests_run++;
      if (len !== 4 * TICK) begin
         tests_failed++;
         $display("[TB] FAIL note43f_len: busy cycles=%0d, expected %0d", len, 4 * TICK);
      end
      tests_run++;
      if (qerr !== 0) begin
         tests_failed++;
         $display("[TB] FAIL note43f_wave: q mismatching cycles=%0d, expected 0", qerr);
      end
      tests_run++;
      if (first !== 63 || rises !== 16) begin
         tests_failed++;
         $display("[TB] FAIL note43f_rises: first=%0d rises=%0d, expected first=63 rises=16", first, rises);
      end
      tests_run++;
      if (qend !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL note43f_qend: q=%b at busy fall, expected 0", qend);
      end
   endtask

   // 0x840 still present at the first idle edge starts right away.
   task automatic test_back_to_back();
      int len, qerr, rises, first;
      logic qend;
      tick();
      tests_run++;
      if (bus.busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL b2b_start: busy=%b, expected 1", bus.busy);
      end
      measure_note(64, len, qerr, rises, first, qend);
      bus.command = 12'h000;
      tests_run++;
      if (len !== 8 * TICK) begin
         tests_failed++;
         $display("[TB] FAIL note840_len: busy cycles=%0d, expected %0d", len, 8 * TICK);
      end
      tests_run++;
      if (qerr !== 0 || first !== 64 || rises !== 32) begin
         tests_failed++;
         $display("[TB] FAIL note840_wave: qerr=%0d first=%0d rises=%0d, expected 0/64/32", qerr, first, rises);
      end
   endtask

   // With no command the block stays idle and silent.
   task automatic test_idle_hold();
      int bad;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus.busy !== 1'b0 || bus.q !== 1'b0) bad++;
      end
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("[TB] FAIL idle_hold: active cycles=%0d, expected 0", bad);
      end
   endtask

   // 0x820: 4096 busy cycles, half-period 32, 64 rising edges.
   task automatic test_tone_820();
      int len, qerr, rises, first;
      logic qend;
      bus.command = 12'h820;
      tick();
      bus.command = 12'h000;
      tests_run++;
      if (bus.busy !== 1'b1 || bus.q !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL note820_start: busy=%b q=%b, expected busy=1 q=0", bus.busy, bus.q);
      end
      measure_note(32, len, qerr, rises, first, qend);
      tests_run++;
      if (len !== 8 * TICK || qend !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL note820_len: busy cycles=%0d qend=%b, expected %0d and 0", len, qend, 8 * TICK);
      end
      tests_run++;
      if (qerr !== 0 || first !== 32 || rises !== 64) begin
         tests_failed++;
         $display("[TB] FAIL note820_wave: qerr=%0d first=%0d rises=%0d, expected 0/32/64", qerr, first, rises);
      end
      tick();
      tests_run++;
      if (bus.busy !== 1'b0 || bus.q !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL note820_after: busy=%b q=%b, expected 0/0", bus.busy, bus.q);
      end
   endtask

   // Rest note: busy for one duration unit, q never leaves 0.
   task automatic test_rest();
      int len, qerr, rises, first;
      logic qend;
      bus.command = 12'h100;
      tick();
      bus.command = 12'h000;
      measure_note(0, len, qerr, rises, first, qend);
      tests_run++;
      if (len !== TICK) begin
         tests_failed++;
         $display("[TB] FAIL rest_len: busy cycles=%0d, expected %0d", len, TICK);
      end
      tests_run++;
      if (qerr !== 0 || rises !== 0 || qend !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rest_wave: qerr=%0d rises=%0d qend=%b, expected 0/0/0", qerr, rises, qend);
      end
   endtask

   // Reset pulse at cycle 100 of a 0x43F note aborts it immediately.
   task automatic test_reset_mid_note();
      int bad;
      bus.command = 12'h43F;
      tick();
      bus.command = 12'h000;
      for (int i = 1; i < 100; i++) tick();
      tests_run++;
      if (bus.busy !== 1'b1 || bus.q !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_pre: busy=%b q=%b at cycle 99, expected 1/1", bus.busy, bus.q);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++;
      if (bus.busy !== 1'b0 || bus.q !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_abort: busy=%b q=%b, expected 0/0", bus.busy, bus.q);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.busy !== 1'b0 || bus.q !== 1'b0) bad++;
      end
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("[TB] FAIL reset_idle: active cycles=%0d, expected 0", bad);
      end
   endtask

   // Reset wins over a simultaneously valid command.
   task automatic test_reset_priority();
      reset       = 1'b1;
      bus.command = 12'h43F;
      tick();
      tests_run++;
      if (bus.busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_prio: busy=%b during reset with command, expected 0", bus.busy);
      end
      reset       = 1'b0;
      bus.command = 12'h000;
      tick();
      tests_run++;
      if (bus.busy !== 1'b0 || bus.q !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_prio_after: busy=%b q=%b, expected 0/0", bus.busy, bus.q);
      end
   endtask

   initial begin
      bus.command = 12'h43F;
      $display("[TB] music_sequencer directed bench start");
      test_power_up();
      test_back_to_back();
      test_idle_hold();
      test_tone_820();
      test_rest();
      test_reset_mid_note();
      test_reset_priority();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
